// File: rtl/lcd2vga_pkg.sv
// lcd2vga_pkg: shared types and timing defaults for the LCD-to-VGA frame lock.
// Holds the lock FSM state encoding, the 640x480@60 timing defaults and the
// helper that sums a timing group into its total period.
package lcd2vga_pkg;

   typedef enum logic [1:0] {
      ST_SEARCH  = 2'd0,
      ST_ACQUIRE = 2'd1,
      ST_LOCKED  = 2'd2,
      ST_HOLD    = 2'd3
   } lock_state_t;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;

   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   // Total period of one timing axis (clocks per line or lines per frame).
   function automatic int timing_total(input int active, input int fp,
                                       input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

endpackage

// File: rtl/lcd2vga_sync_detect.sv
// lcd2vga_sync_detect: finds LCD frame starts.
// A frame start is a rising edge of the LCD line sync that follows a quiet
// stretch longer than GAP_MIN clocks. The gap counter saturates so that a
// vanished source never wraps into a false short gap, and it comes out of
// reset saturated so the very first rise counts as a frame start.
module lcd2vga_sync_detect #(
   parameter int GAP_MIN = 1000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sync,
   output logic fs
);

   localparam int GW = $clog2(GAP_MIN + 2);
   localparam logic [GW-1:0] GAP_THR = GW'(GAP_MIN);

   logic          sync_q;
   logic [GW-1:0] gap;
   logic          rise;

   // Saturating increment: holds at all-ones once reached.
   function automatic logic [GW-1:0] sat_inc(input logic [GW-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

   assign rise = sync & ~sync_q;
   // Qualification uses the gap value from before this rise clears it.
   assign fs   = rise & (gap > GAP_THR);

   // Previous sync level for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= 1'b0;
      else        sync_q <= sync;
   end

   // Clocks since the last rise, saturating.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    gap <= '1;
      else if (rise) gap <= '0;
      else           gap <= sat_inc(gap);
   end

endmodule

// File: rtl/lcd2vga_frame_lock.sv
// lcd2vga_frame_lock: frame-locked VGA timing generator for the LCD tap.
// Local H/V counters are realigned to LCD frame starts while acquiring, then
// free-run once locked; lock is kept through isolated misaligned frames.
// Optional build macro LCD2VGA_WDOG_EN adds a watchdog that treats a silent
// LCD (no frame start for WDOG_CLKS clocks) as a misaligned frame start.
module lcd2vga_frame_lock
   import lcd2vga_pkg::*;
#(
   parameter int CBITS       = 1,
   parameter int H_ACTIVE    = DEF_H_ACTIVE,
   parameter int H_FP        = DEF_H_FP,
   parameter int H_SYNC      = DEF_H_SYNC,
   parameter int H_BP        = DEF_H_BP,
   parameter int V_ACTIVE    = DEF_V_ACTIVE,
   parameter int V_FP        = DEF_V_FP,
   parameter int V_SYNC      = DEF_V_SYNC,
   parameter int V_BP        = DEF_V_BP,
   parameter int GAP_MIN     = 1000,
   parameter int LOCK_FRAMES = 4,
   parameter int MISS_MAX    = 2
`ifdef LCD2VGA_WDOG_EN
   ,
   parameter int WDOG_CLKS   = 840000
`endif
) (
   input  logic             iw_clk,
   input  logic             iw_rst_n,
   input  logic             iw_sync,
   input  logic [CBITS-1:0] iw_r,
   input  logic [CBITS-1:0] iw_g,
   input  logic [CBITS-1:0] iw_b,
   output logic [CBITS-1:0] ow_r,
   output logic [CBITS-1:0] ow_g,
   output logic [CBITS-1:0] ow_b,
   output logic             ow_hsync,
   output logic             ow_vsync,
   output logic             ow_locked,
   output logic [1:0]       ow_state,
   output logic             ow_frame_start
);

   localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam int HW      = $clog2(H_TOTAL + 1);
   localparam int VW      = $clog2(V_TOTAL + 1);

   localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT_END = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_BEG    = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END    = HW'(H_ACTIVE + H_FP + H_SYNC);

   localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT_END = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_BEG    = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END    = VW'(V_ACTIVE + V_FP + V_SYNC);

   localparam int HIT_W  = $clog2(LOCK_FRAMES + 1);
   localparam int MISS_W = $clog2(MISS_MAX + 1);

   lock_state_t       state;
   logic [HIT_W-1:0]  hits;
   logic [MISS_W-1:0] misses;
   logic              locked;

   logic [HW-1:0]     hpos;
   logic [VW-1:0]     vpos;

   logic              fs;
   logic              at_end;
   logic              ev_aligned;
   logic              ev_miss;
   logic              wdog_hit;
   logic              force_zero;
   logic              pass;

   logic [CBITS-1:0]  r_p1;
   logic [CBITS-1:0]  g_p1;
   logic [CBITS-1:0]  b_p1;
   logic              hsync_p1;
   logic              vsync_p1;
   logic              frame_start_p1;

   lcd2vga_sync_detect #(
      .GAP_MIN (GAP_MIN)
   ) u_sync_detect (
      .clk   (iw_clk),
      .rst_n (iw_rst_n),
      .sync  (iw_sync),
      .fs    (fs)
   );

   // A frame start is aligned when the free-running counters would wrap to
   // (0,0) on this very clock, so forcing and wrapping give the same result.
   assign at_end     = (hpos == H_LAST) && (vpos == V_LAST);
   assign ev_aligned = fs & at_end;
   assign ev_miss    = (fs & ~at_end) | wdog_hit;

   // Counters are only pulled to zero before lock; once locked they free-run.
   assign force_zero = ((state == ST_SEARCH) && fs) ||
                       ((state == ST_ACQUIRE) && ev_miss);

   assign pass = ((state == ST_LOCKED) || (state == ST_HOLD)) &&
                 (hpos < H_ACT_END) && (vpos < V_ACT_END);

`ifdef LCD2VGA_WDOG_EN
   localparam int WW = $clog2(WDOG_CLKS + 1);
   localparam logic [WW-1:0] WDOG_LIM = WW'(WDOG_CLKS);

   logic [WW-1:0] wdog_cnt;

   // A real frame start always wins over a simultaneous timeout.
   assign wdog_hit = ~fs && (state != ST_SEARCH) && (wdog_cnt == WDOG_LIM);

   // Clocks since the last frame start; restarts after each timeout.
   always_ff @(posedge iw_clk or negedge iw_rst_n) begin
      if (!iw_rst_n)              wdog_cnt <= '0;
      else if (fs || wdog_hit)    wdog_cnt <= '0;
      else if (wdog_cnt != WDOG_LIM) wdog_cnt <= wdog_cnt + 1'b1;
   end
`else
   assign wdog_hit = 1'b0;
`endif

   // Horizontal/vertical raster counters with frame-start realignment.
   always_ff @(posedge iw_clk or negedge iw_rst_n) begin
      if (!iw_rst_n) begin
         hpos <= '0;
         vpos <= '0;
      end else if (force_zero || (hpos == H_LAST)) begin
         hpos <= '0;
         if (force_zero || (vpos == V_LAST)) vpos <= '0;
         else                                vpos <= vpos + 1'b1;
      end else begin
         hpos <= hpos + 1'b1;
      end
   end

   // Lock qualification FSM with registered lock flag.
   always_ff @(posedge iw_clk or negedge iw_rst_n) begin
      if (!iw_rst_n) begin
         state  <= ST_SEARCH;
         hits   <= '0;
         misses <= '0;
         locked <= 1'b0;
      end else begin
         case (state)
            ST_SEARCH: begin
               if (fs) begin
                  hits   <= '0;
                  misses <= '0;
                  state  <= ST_ACQUIRE;
               end
            end
            ST_ACQUIRE: begin
               if (ev_aligned) begin
                  hits <= hits + 1'b1;
                  if (int'(hits) + 1 >= LOCK_FRAMES - 1) begin
                     state  <= ST_LOCKED;
                     locked <= 1'b1;
                     misses <= '0;
                  end
               end else if (ev_miss) begin
                  hits <= '0;
               end
            end
            ST_LOCKED: begin
               if (ev_aligned) begin
                  misses <= '0;
               end else if (ev_miss) begin
                  misses <= MISS_W'(1);
                  state  <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (ev_aligned) begin
                  misses <= '0;
                  state  <= ST_LOCKED;
               end else if (ev_miss) begin
                  if (int'(misses) + 1 >= MISS_MAX) begin
                     misses <= '0;
                     hits   <= '0;
                     locked <= 1'b0;
                     state  <= ST_SEARCH;
                  end else begin
                     misses <= misses + 1'b1;
                  end
               end
            end
         endcase
      end
   end

   // Output stage: gated colour and syncs from the same counter sample.
   always_ff @(posedge iw_clk or negedge iw_rst_n) begin
      if (!iw_rst_n) begin
         r_p1           <= '0;
         g_p1           <= '0;
         b_p1           <= '0;
         hsync_p1       <= 1'b1;
         vsync_p1       <= 1'b1;
         frame_start_p1 <= 1'b0;
      end else begin
         r_p1           <= pass ? iw_r : '0;
         g_p1           <= pass ? iw_g : '0;
         b_p1           <= pass ? iw_b : '0;
         hsync_p1       <= ~((hpos >= HS_BEG) && (hpos < HS_END));
         vsync_p1       <= ~((vpos >= VS_BEG) && (vpos < VS_END));
         frame_start_p1 <= fs;
      end
   end

   assign ow_r           = r_p1;
   assign ow_g           = g_p1;
   assign ow_b           = b_p1;
   assign ow_hsync       = hsync_p1;
   assign ow_vsync       = vsync_p1;
   assign ow_locked      = locked;
   assign ow_state       = state;
   assign ow_frame_start = frame_start_p1;

endmodule

// File: tb/tb_lcd2vga_frame_lock.sv
// tb_lcd2vga_frame_lock: scoreboard bench for the LCD-to-VGA frame lock.
// Uses a reduced 24x12 raster (288-clock frames) so many frames fit in a
// short run. Frame starts push their expected arrival cycle and state; the
// frame-start monitor pops and compares. Selected frames are checked
// cycle by cycle against the raster position implied by the LCD schedule.
module tb_lcd2vga_frame_lock;

   localparam int HT = 24;
   localparam int VT = 12;
   localparam int FT = HT * VT;

   logic       clk;
   logic       rst_n;
   logic       sync;
   logic [2:0] in_r, in_g, in_b;
   logic [2:0] out_r, out_g, out_b;
   logic       hsync, vsync, locked, frame_start;
   logic [1:0] state;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   typedef struct {
      int cyc;
      int st;
   } fs_exp_t;

   fs_exp_t sb[$];

   typedef struct {
      int len;
      int st;
      int mode;
      int p0;
      int rst_at;
   } frame_t;

   // len, state after this frame's start, check mode, raster pos at start, reset offset
   frame_t plan[18] = '{
      '{288, 1, 0,   0,  -1},
      '{288, 1, 0,   0,  -1},
      '{288, 1, 0,   0,  -1},
      '{288, 2, 0,   0,  -1},
      '{285, 2, 1, 287,  -1},
      '{291, 3, 1, 284,  -1},
      '{338, 2, 1, 287,  -1},
      '{288, 3, 1,  49,  -1},
      '{288, 0, 2,   0,  -1},
      '{288, 1, 0,   0,  -1},
      '{288, 1, 0,   0,  -1},
      '{288, 1, 0,   0,  -1},
      '{288, 2, 0,   0, 250},
      '{288, 1, 0,   0,  -1},
      '{288, 1, 0,   0,  -1},
      '{288, 1, 0,   0,  -1},
      '{288, 2, 0,   0,  -1},
      '{288, 2, 1, 287,  -1}
   };

   lcd2vga_frame_lock #(
      .CBITS       (3),
      .H_ACTIVE    (16),
      .H_FP        (2),
      .H_SYNC      (4),
      .H_BP        (2),
      .V_ACTIVE    (8),
      .V_FP        (1),
      .V_SYNC      (2),
      .V_BP        (1),
      .GAP_MIN     (40),
      .LOCK_FRAMES (4),
      .MISS_MAX    (2)
`ifdef LCD2VGA_WDOG_EN
      ,
      .WDOG_CLKS   (1000)
`endif
   ) dut (
      .iw_clk         (clk),
      .iw_rst_n       (rst_n),
      .iw_sync        (sync),
      .iw_r           (in_r),
      .iw_g           (in_g),
      .iw_b           (in_b),
      .ow_r           (out_r),
      .ow_g           (out_g),
      .ow_b           (out_b),
      .ow_hsync       (hsync),
      .ow_vsync       (vsync),
      .ow_locked      (locked),
      .ow_state       (state),
      .ow_frame_start (frame_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Frame-start monitor: every pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (frame_start === 1'b1) begin
         if (sb.size() == 0) begin
            chk("fs_unexpected", 1, 0);
         end else begin
            fs_exp_t e;
            e = sb.pop_front();
            chk("fs_cycle", cyc, e.cyc);
            chk("fs_state", int'(state), e.st);
            chk("fs_locked", int'(locked), (e.st >= 2) ? 1 : 0);
         end
      end
   end

   task automatic check_reset_values(input string where);
      chk({where, "_r"}, int'(out_r), 0);
      chk({where, "_g"}, int'(out_g), 0);
      chk({where, "_b"}, int'(out_b), 0);
      chk({where, "_hsync"}, int'(hsync), 1);
      chk({where, "_vsync"}, int'(vsync), 1);
      chk({where, "_locked"}, int'(locked), 0);
      chk({where, "_state"}, int'(state), 0);
      chk({where, "_fs"}, int'(frame_start), 0);
   endtask

   // Outputs at offset k reflect the raster position one clock earlier.
   task automatic check_pixel(input int k, input int p0);
      int pos, h, v;
      bit act;
      pos = (p0 + k - 1 + FT) % FT;
      h   = pos % HT;
      v   = pos / HT;
      act = (h < 16) && (v < 8);
      chk("hsync", int'(hsync), (h >= 18 && h < 22) ? 0 : 1);
      chk("vsync", int'(vsync), (v >= 9 && v < 11) ? 0 : 1);
      chk("rgb_r", int'(out_r), act ? 7 : 0);
      chk("rgb_g", int'(out_g), act ? 5 : 0);
      chk("rgb_b", int'(out_b), act ? 3 : 0);
      chk("locked_on", int'(locked), 1);
   endtask

   task automatic drive_frame(input frame_t f);
      for (int k = 0; k < f.len; k++) begin
         @(posedge clk);
         #1;
         sync = (k < 10 * HT) && ((k % HT) < 4);
         if (k == 0) sb.push_back('{cyc + 1, f.st});
         if (f.mode == 1) check_pixel(k, f.p0);
         if (f.mode == 2) begin
            if (k >= 1) begin
               chk("search_locked", int'(locked), 0);
               chk("search_state", int'(state), 0);
            end
            if (k >= 2) begin
               chk("search_r", int'(out_r), 0);
               chk("search_g", int'(out_g), 0);
               chk("search_b", int'(out_b), 0);
            end
         end
         if (f.rst_at >= 0 && k == f.rst_at) begin
            chk("pre_rst_locked", int'(locked), 1);
            #2 rst_n = 1'b0;
            #1 check_reset_values("midrst");
         end
         if (f.rst_at >= 0 && k == f.rst_at + 3) rst_n = 1'b1;
      end
   endtask

   initial begin
      #(100000 * 10);
      $display("FAIL timeout: got running, expected finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      rst_n = 1'b0;
      sync  = 1'b0;
      in_r  = 3'b111;
      in_g  = 3'b101;
      in_b  = 3'b011;
      repeat (3) @(posedge clk);
      #1 check_reset_values("rst");
      rst_n = 1'b1;
      repeat (5) @(posedge clk);

      foreach (plan[i]) drive_frame(plan[i]);

      // LCD goes silent right after an aligned frame start.
      for (int k = 0; k < 2200; k++) begin
         @(posedge clk);
         #1;
         sync = (k < 4);
         if (k == 0) sb.push_back('{cyc + 1, 2});
         if (k == 900) chk("silent_900_state", int'(state), 2);
`ifdef LCD2VGA_WDOG_EN
         if (k == 1100) begin
            chk("wdog_hold_state", int'(state), 3);
            chk("wdog_hold_locked", int'(locked), 1);
         end
         if (k == 2100) begin
            chk("wdog_search_state", int'(state), 0);
            chk("wdog_search_locked", int'(locked), 0);
         end
`else
         if (k == 2100) begin
            chk("silent_state", int'(state), 2);
            chk("silent_locked", int'(locked), 1);
         end
`endif
      end

      repeat (2) @(posedge clk);
      #1 chk("fs_pending", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/lcd2vga_frame_lock.md
# lcd2vga_frame_lock

Parametrised, frame-locked VGA timing generator for the HP5454x LCD tap. It sits between the scope's LCD bus and the VGA connector. It measures gaps between LCD sync pulses to find the frame boundary and realigns its own H/V counters there. It qualifies lock over several frames, drives registered HSYNC/VSYNC, and gates the N-bit-per-channel RGB to the active area.

## Interface
Parameters:
- CBITS, 1: bits per colour channel (1..3).
- H_ACTIVE, 640 / H_FP, 16 / H_SYNC, 96 / H_BP, 48: horizontal timing in clocks; H_TOTAL is their sum (800).
- V_ACTIVE, 480 / V_FP, 10 / V_SYNC, 2 / V_BP, 33: vertical timing in lines; V_TOTAL is their sum (525).
- GAP_MIN, 1000: a sync rising edge preceded by more than GAP_MIN clocks without one is a frame start.
- LOCK_FRAMES, 4: consecutive aligned frame starts required to lock.
- MISS_MAX, 2: consecutive misaligned or missing frame starts that drop lock.
- WDOG_CLKS, 840000: watchdog timeout in clocks (macro build only).

Ports:
- iw_clk  in  1  LCD pixel clock; all logic on its rising edge.
- iw_rst_n  in  1  Asynchronous active-low reset.
- iw_sync  in  1  LCD line sync, synchronous to iw_clk.
- iw_r, iw_g, iw_b  in  CBITS each  LCD colour data.
- ow_r, ow_g, ow_b  out  CBITS each  Gated VGA colour.
- ow_hsync, ow_vsync  out  1  Active-low VGA syncs.
- ow_locked  out  1  High in LOCKED.
- ow_state  out  2  FSM state code.
- ow_frame_start  out  1  One-cycle pulse per detected frame start.

## Operation
- Edge detect: sync_q <= iw_sync. A rise is iw_sync & ~sync_q.
- Gap counter: cleared on each rise, otherwise incremented. It saturates at all-ones and its width is $clog2(GAP_MIN+2). fs = rise & (gap > GAP_MIN).
- H/V counters: hpos runs 0..H_TOTAL-1. At wrap, vpos increments, running 0..V_TOTAL-1 then wrapping to 0.
- Aligned: fs arrives when the next counter value is hpos==0 and vpos==0. Anything else is misaligned.
- FSM states: SEARCH=0, ACQUIRE=1, LOCKED=2, HOLD=3.
  - SEARCH: on fs, force hpos=0 and vpos=0 on the next clock, clear hits, go to ACQUIRE.
  - ACQUIRE: each aligned fs increments hits. When hits reaches LOCK_FRAMES-1, go to LOCKED. A misaligned fs forces the counters to 0, clears hits and stays in ACQUIRE.
  - LOCKED: counters free-run and are never forced. An aligned fs clears misses. A misaligned fs sets misses=1 and goes to HOLD.
  - HOLD: an aligned fs clears misses and returns to LOCKED. A misaligned fs increments misses. When misses reaches MISS_MAX, go to SEARCH.
- Output gating: RGB is passed only in LOCKED or HOLD, and only when hpos<H_ACTIVE and vpos<V_ACTIVE. Otherwise RGB is 0.
- Sync generation:
  - ow_hsync is low for H_ACTIVE+H_FP <= hpos < H_ACTIVE+H_FP+H_SYNC.
  - ow_vsync is low for V_ACTIVE+V_FP <= vpos < V_ACTIVE+V_FP+V_SYNC.
  - Syncs are generated in every state, so the monitor keeps its mode.
- Simultaneous events: when fs coincides with the counter wrap, the force and the wrap both produce 0, so the result is identical. A rise resets the gap counter in the same cycle that fs is evaluated on the pre-reset value.

## Timing
- Reset values:
  - Outputs: RGB=0, ow_hsync=1, ow_vsync=1, ow_locked=0, ow_state=SEARCH, ow_frame_start=0.
  - Internal: counters 0, gap counter saturated (the first rise is a frame start), hits=0, misses=0, sync_q=0.
- All outputs are registered.
- RGB latency is 1 clock. Syncs come from the same-cycle counter and are registered, so they are aligned with RGB.
- ow_frame_start is asserted the cycle after the qualifying rise.
- ow_locked rises the cycle after the LOCK_FRAMES-th aligned fs.
- Reset asserted mid-frame takes effect immediately and asynchronously.

## Configuration
- LCD2VGA_WDOG_EN defined: a watchdog counter is cleared on every fs. If it reaches WDOG_CLKS while in ACQUIRE, LOCKED or HOLD, it is treated as one misaligned fs (same transitions) and the watchdog is cleared.
- Not defined: no watchdog. A vanished LCD leaves the FSM in its current state indefinitely.

## Structure
- Package lcd2vga_pkg holds:
  - the state enum and its 2-bit encodings;
  - the default 640x480@60 timing constants;
  - a function returning H_TOTAL and V_TOTAL.
- Sub-module lcd2vga_sync_detect contains the edge detector and gap counter, and outputs fs. The top holds the counters, FSM and output stage.

## Test plan
- Clean LCD source: lines of 800 clocks, sync gap 36000 clocks per frame, 525-line frames.
  - Required: fs every 420000 clocks; ow_locked rises after the 4th aligned frame start.
  - Required: ow_hsync low for 96 clocks per line; ow_vsync low for 2 lines per frame.
- Locked, single frame start 3 clocks early: state goes to HOLD, ow_locked stays 1, counters do not jump. The next aligned frame start returns to LOCKED.
- Locked, two consecutive frame starts offset by 50 clocks: state goes to SEARCH, ow_locked=0, RGB=0. The next frame start forces the counters and enters ACQUIRE.
- Pixel data all-ones on every channel with CBITS=3: output is 3'b111 only for hpos<640 and vpos<480 in LOCKED; 0 in the porches and in SEARCH.
- iw_rst_n pulsed low mid-frame in LOCKED: all outputs take their reset values immediately. Relock takes 4 frames.
- With LCD2VGA_WDOG_EN and WDOG_CLKS=1000: sync stops while LOCKED → HOLD after 1000 clocks, SEARCH after 2000 clocks.
